timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- Memory-mapped countdown timer, instanced twice (TC0, TC1) on the processor's system bus, directly downstream of the bus bridge.
- The bridge's per-device write strobe, pass-through address and write data drive it. Its read data returns to the bridge's read mux.
- Its IRQ output feeds the CP0 external-interrupt inputs (HWInt).
- Three 32-bit registers: CTRL, PRESET and COUNT. Two modes: one-shot and auto-reload.

Parameters:
None. Register width is fixed at 32; the register map is fixed.

Ports:
clk    input   1   system clock, rising edge
reset  input   1   synchronous, active-high
Addr   input   32  bus address; only Addr[3:2] is decoded (word select), all other bits ignored
WE     input   1   write strobe; high only when the bridge decodes this device and the access is a full word
Din    input   32  write data
Dout   output  32  read data, combinational from Addr[3:2]
IRQ    output  1   interrupt request, level

Behaviour:
- Register map by Addr[3:2]:
  - 0 = CTRL: bit0 En, bits2:1 Mode, bit3 IM (interrupt mask); bits31:4 read 0.
  - 1 = PRESET: R/W, all 32 bits.
  - 2 = COUNT: read-only; writes ignored.
  - 3: reads 0, writes ignored.
- Writes take effect at the rising clk edge with WE=1.
  - CTRL write stores Din[3:0] and clears irq_pending.
  - Mode values 2 and 3 behave as Mode 0.
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_pending=0, state=IDLE, so IRQ=0. Reset overrides everything, including a coincident write and any count in progress.
- FSM states, evaluated each edge after write decode:
  - IDLE: if En=1, go to LOAD; else stay.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT: if En=0, go to IDLE with COUNT frozen (no interrupt). Else if COUNT>1, COUNT <= COUNT-1 and stay. Else (COUNT is 1 or 0), COUNT <= 0, irq_pending <= 1, go to INT.
  - INT, Mode 0: clear CTRL.En; irq_pending holds; go to IDLE.
  - INT, Mode 1: irq_pending <= 0; go to IDLE. En is still 1, so the timer reloads.
- IRQ = irq_pending & CTRL.IM.
  - Mode 0: IRQ is a level that stays high until software writes CTRL.
  - Mode 1: IRQ is a one-cycle pulse per period.
- Timing for PRESET=N (N≥1), measured from the CTRL write edge e0 with En=1:
  - LOAD is taken at e1; COUNT=N at e2.
  - COUNT reaches 0 and irq_pending sets at e(N+2).
  - Mode 1 period is N+3 cycles.
  - PRESET=0 behaves like PRESET=1.
- Simultaneous events:
  - A CTRL write in the same cycle the FSM is in INT wins: the written En value is kept. irq_pending is still cleared.
  - A PRESET write during CNT does not affect COUNT until the next LOAD.
  - Writing En=0 during LOAD: COUNT is loaded, then CNT sees En=0 and goes to IDLE.
  - Re-enabling from IDLE always reloads from PRESET; there is no resume.
- Dout is purely combinational, with no read side effects. Reading COUNT returns the value registered at the last edge.

Test Plan:
- Reset: assert reset for 2 cycles mid-count (COUNT=5) -> next cycle CTRL=0, COUNT=0, PRESET=0, IRQ=0, Dout at Addr 0x8 = 0.
- One-shot: write PRESET=3, then CTRL=0x9 -> COUNT reads 3, 2, 1, 0 on edges e2..e5. IRQ goes high after e5 and stays high, and CTRL reads 0x8 after e6. Writing CTRL=0x8 drops IRQ the next cycle.
- Auto-reload: PRESET=2, CTRL=0xB -> IRQ is high for exactly 1 cycle, every 5 cycles, for at least 3 periods. COUNT cycles 2, 1, 0, 0, 0 per period.
- Mask: PRESET=2, CTRL=0x1 -> IRQ stays 0 throughout, and CTRL.En clears after the count expires. Then writing CTRL=0x8 with irq_pending set yields IRQ=0 (the write clears pending).
- Disable mid-count: PRESET=10, CTRL=0x9, then after COUNT=7 write CTRL=0x8 -> COUNT freezes at 6 or 7 per the edge rule, with no IRQ. Re-enabling with CTRL=0x9 reloads 10.
- Bus decode: WE=1 with Addr[3:2]=2 or 3 and Din=0xFFFFFFFF -> no register changes. A read at Addr 0xC returns 0. CTRL write Din=0xFFFFFFFF reads back 0xF.

Source files
------------

// File: rtl/timer_counter.sv
// -----------------------------------------------------------------------------
// timer_counter
// Memory-mapped 32-bit countdown timer with one-shot and auto-reload modes.
//
// Ports
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous, active-high; overrides any write or count
//   Addr   in  32   bus address, only Addr[3:2] selects a register
//   WE     in   1   full-word write strobe for this device
//   Din    in  32   write data
//   Dout   out 32   read data, combinational from Addr[3:2]
//   IRQ    out  1   interrupt request level (irq_pending & CTRL.IM)
//
// Register map (Addr[3:2])
//   0 CTRL   : bit0 En, bits2:1 Mode (1 = auto-reload, others = one-shot),
//              bit3 IM; writing CTRL clears the pending interrupt
//   1 PRESET : reload value
//   2 COUNT  : current count, read-only
//   3        : reads 0, writes ignored
// -----------------------------------------------------------------------------
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_AUTO   = 2'd1;

  state_t      r_state;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_pend;
  logic        r_irq;

  state_t      w_state_nxt;
  logic [3:0]  w_ctrl_nxt;
  logic [31:0] w_preset_nxt;
  logic [31:0] w_count_nxt;
  logic        w_pend_nxt;
  logic        w_ctrl_wr;
  logic        w_preset_wr;
  logic        w_en;
  logic        w_auto;
  logic        w_unused_addr;

  // Address bits outside the word select are intentionally ignored.
  assign w_unused_addr = ^{Addr[31:4], Addr[1:0]};

  assign w_ctrl_wr   = WE && (Addr[3:2] == ADDR_CTRL);
  assign w_preset_wr = WE && (Addr[3:2] == ADDR_PRESET);
  assign w_en        = r_ctrl[0];
  assign w_auto      = (r_ctrl[2:1] == MODE_AUTO);

  // Write decode first, then the FSM acts on the registered state/CTRL.
  always_comb begin
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_ctrl_nxt   = r_ctrl;
    w_pend_nxt   = r_pend;
    w_preset_nxt = r_preset;

    if (w_ctrl_wr) begin
      w_ctrl_nxt = Din[3:0];
      w_pend_nxt = 1'b0;
    end else begin
      w_ctrl_nxt = r_ctrl;
    end

    if (w_preset_wr) begin
      w_preset_nxt = Din;
    end else begin
      w_preset_nxt = r_preset;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_en) begin
          w_state_nxt = ST_LOAD;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = ST_CNT;
      end
      ST_CNT: begin
        if (!w_en) begin
          w_state_nxt = ST_IDLE;
        end else if (r_count > 32'd1) begin
          w_count_nxt = r_count - 32'd1;
        end else begin
          // Expiry at 1 or 0 keeps PRESET=0 behaving like PRESET=1.
          w_count_nxt = 32'd0;
          w_pend_nxt  = 1'b1;
          w_state_nxt = ST_INT;
        end
      end
      ST_INT: begin
        if (w_auto) begin
          w_pend_nxt = 1'b0;
        end else if (!w_ctrl_wr) begin
          // One-shot stops itself unless software rewrote CTRL this cycle.
          w_ctrl_nxt[0] = 1'b0;
        end else begin
          w_ctrl_nxt = Din[3:0];
        end
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and register update with synchronous reset priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_ctrl   <= 4'd0;
      r_preset <= 32'd0;
      r_count  <= 32'd0;
      r_pend   <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_ctrl   <= w_ctrl_nxt;
      r_preset <= w_preset_nxt;
      r_count  <= w_count_nxt;
      r_pend   <= w_pend_nxt;
      // Registered copy of pending & IM, identical in timing to the AND of the registers.
      r_irq    <= w_pend_nxt & w_ctrl_nxt[3];
    end
  end

  assign IRQ = r_irq;

  // Combinational read mux, no read side effects.
  always_comb begin
    Dout = 32'd0;
    case (Addr[3:2])
      ADDR_CTRL:   Dout = {28'd0, r_ctrl};
      ADDR_PRESET: Dout = r_preset;
      ADDR_COUNT:  Dout = r_count;
      default:     Dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Self-checking bench for timer_counter: directed scenarios plus randomized
// runs checked against a timing-formula reference model.
module tb_timer_counter;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  int n_checks;
  int n_pass;

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read a register; upper address bits are randomized to exercise decode.
  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    logic [31:0] r;
    r = $urandom;
    Addr = {r[31:4], a[3:2], r[1:0]};
    #1;
    d = Dout;
  endtask

  // Full-word write; returns 1 time unit after the write edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] data);
    @(negedge clk);
    Addr = {28'd0, a};
    Din  = data;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE   = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model: COUNT after edge k of the CTRL-enable write (k>=1).
  function automatic logic [31:0] model_count(input int n, input bit auto_m, input int k);
    int nn, p;
    nn = (n == 0) ? 1 : n;
    if (k < 2) return 32'd0;
    p = auto_m ? (k - 2) % (nn + 3) : (k - 2);
    if (p == 0) return n;
    if (p < nn) return nn - p;
    return 32'd0;
  endfunction

  function automatic bit model_pend(input int n, input bit auto_m, input int k);
    int nn;
    nn = (n == 0) ? 1 : n;
    if (k < 2) return 1'b0;
    if (auto_m) return ((k - 2) % (nn + 3)) == nn;
    return k >= nn + 2;
  endfunction

  function automatic bit model_en(input int n, input bit auto_m, input int k);
    int nn;
    nn = (n == 0) ? 1 : n;
    if (auto_m) return 1'b1;
    return k < nn + 3;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    bit found;
    do_reset();
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h9);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      rd(4'h8, d);
      if (d == 32'd5) found = 1'b1;
      else @(posedge clk);
    end
    n_checks++;
    if (!found) $display("FAIL reset_wait_count5: COUNT never reached 5 (last %0d)", d);
    else n_pass++;
    // Reset with a coincident PRESET write: reset must win.
    @(negedge clk);
    reset = 1'b1; WE = 1'b1; Addr = 32'h4; Din = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; WE = 1'b0;
    rd(4'h0, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL reset_ctrl: got %h expected %h", d, 32'd0); else n_pass++;
    rd(4'h8, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL reset_count: got %h expected %h", d, 32'd0); else n_pass++;
    rd(4'h4, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL reset_preset: got %h expected %h", d, 32'd0); else n_pass++;
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL reset_irq: got %b expected 0", IRQ); else n_pass++;
    repeat (3) @(posedge clk);
    #1;
    rd(4'h8, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL reset_idle_count: got %h expected 0", d); else n_pass++;
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    logic [31:0] exp_cnt [1:6];
    logic        exp_irq [1:6];
    logic [31:0] exp_ctl [1:6];
    exp_cnt = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_ctl = '{32'h9, 32'h9, 32'h9, 32'h9, 32'h9, 32'h8};
    do_reset();
    wr(4'h4, 32'd3);
    wr(4'h0, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      rd(4'h8, d);
      n_checks++;
      if (d !== exp_cnt[k]) $display("FAIL oneshot_count_e%0d: got %0d expected %0d", k, d, exp_cnt[k]); else n_pass++;
      n_checks++;
      if (IRQ !== exp_irq[k]) $display("FAIL oneshot_irq_e%0d: got %b expected %b", k, IRQ, exp_irq[k]); else n_pass++;
      rd(4'h0, d);
      n_checks++;
      if (d !== exp_ctl[k]) $display("FAIL oneshot_ctrl_e%0d: got %h expected %h", k, d, exp_ctl[k]); else n_pass++;
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (IRQ !== 1'b1) $display("FAIL oneshot_irq_hold: got %b expected 1", IRQ); else n_pass++;
    wr(4'h0, 32'h8);
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL oneshot_irq_clear: got %b expected 0", IRQ); else n_pass++;
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    logic [31:0] exp_c;
    logic        exp_i;
    int pulses;
    pulses = 0;
    do_reset();
    wr(4'h4, 32'd2);
    wr(4'h0, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      exp_i = (k >= 4) && ((k - 4) % 5 == 0);
      if (k < 2) exp_c = 32'd0;
      else if ((k - 2) % 5 == 0) exp_c = 32'd2;
      else if ((k - 2) % 5 == 1) exp_c = 32'd1;
      else exp_c = 32'd0;
      rd(4'h8, d);
      n_checks++;
      if (d !== exp_c) $display("FAIL auto_count_e%0d: got %0d expected %0d", k, d, exp_c); else n_pass++;
      n_checks++;
      if (IRQ !== exp_i) $display("FAIL auto_irq_e%0d: got %b expected %b", k, IRQ, exp_i); else n_pass++;
      if (IRQ === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 4) $display("FAIL auto_pulse_count: got %0d expected 4", pulses); else n_pass++;
  endtask

  task automatic test_mask();
    logic [31:0] d;
    int highs;
    highs = 0;
    do_reset();
    wr(4'h4, 32'd2);
    wr(4'h0, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (IRQ !== 1'b0) highs++;
    end
    n_checks++;
    if (highs != 0) $display("FAIL mask_irq_low: got %0d high cycles expected 0", highs); else n_pass++;
    rd(4'h0, d);
    n_checks++;
    if (d !== 32'h0) $display("FAIL mask_en_cleared: got %h expected %h", d, 32'h0); else n_pass++;
    wr(4'h0, 32'h8);
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL mask_write_clears: got %b expected 0", IRQ); else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL mask_write_clears_later: got %b expected 0", IRQ); else n_pass++;
  endtask

  task automatic test_disable();
    logic [31:0] d;
    bit found;
    int highs;
    highs = 0;
    do_reset();
    wr(4'h4, 32'd10);
    wr(4'h0, 32'h9);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      rd(4'h8, d);
      if (d == 32'd7) found = 1'b1;
      else @(posedge clk);
    end
    n_checks++;
    if (!found) $display("FAIL disable_wait_count7: COUNT never reached 7 (last %0d)", d);
    else n_pass++;
    // Write lands on the next edge, which still decrements to 6.
    wr(4'h0, 32'h8);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (IRQ !== 1'b0) highs++;
    end
    rd(4'h8, d);
    n_checks++;
    if (d !== 32'd6) $display("FAIL disable_freeze: got %0d expected 6", d); else n_pass++;
    n_checks++;
    if (highs != 0) $display("FAIL disable_no_irq: got %0d high cycles expected 0", highs); else n_pass++;
    wr(4'h0, 32'h9);
    @(posedge clk); #1;
    rd(4'h8, d);
    n_checks++;
    if (d !== 32'd6) $display("FAIL reenable_e1: got %0d expected 6", d); else n_pass++;
    @(posedge clk); #1;
    rd(4'h8, d);
    n_checks++;
    if (d !== 32'd10) $display("FAIL reenable_reload: got %0d expected 10", d); else n_pass++;
  endtask

  task automatic test_int_write();
    logic [31:0] d;
    do_reset();
    wr(4'h4, 32'd1);
    wr(4'h0, 32'h9);
    repeat (3) @(posedge clk);
    // Edge e4: FSM in INT, CTRL rewritten with En=1 at the same edge.
    wr(4'h0, 32'h9);
    rd(4'h0, d);
    n_checks++;
    if (d !== 32'h9) $display("FAIL intwr_ctrl_kept: got %h expected %h", d, 32'h9); else n_pass++;
    n_checks++;
    if (IRQ !== 1'b0) $display("FAIL intwr_pend_cleared: got %b expected 0", IRQ); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    rd(4'h8, d);
    n_checks++;
    if (d !== 32'd1) $display("FAIL intwr_reload: got %0d expected 1", d); else n_pass++;
  endtask

  task automatic test_bus_decode();
    logic [31:0] d;
    do_reset();
    wr(4'h4, 32'h1234_5678);
    wr(4'h8, 32'hFFFF_FFFF);
    wr(4'hC, 32'hFFFF_FFFF);
    rd(4'h4, d);
    n_checks++;
    if (d !== 32'h1234_5678) $display("FAIL decode_preset: got %h expected %h", d, 32'h1234_5678); else n_pass++;
    rd(4'h8, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL decode_count_ro: got %h expected %h", d, 32'd0); else n_pass++;
    rd(4'h0, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL decode_ctrl: got %h expected %h", d, 32'd0); else n_pass++;
    rd(4'hC, d);
    n_checks++;
    if (d !== 32'd0) $display("FAIL decode_addr_c: got %h expected %h", d, 32'd0); else n_pass++;
    wr(4'h0, 32'hFFFF_FFFF);
    rd(4'h0, d);
    n_checks++;
    if (d !== 32'hF) $display("FAIL decode_ctrl_mask: got %h expected %h", d, 32'hF); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] exp_c;
    logic [31:0] exp_ctl;
    logic        exp_i;
    int n, mode, im, nn, kmax;
    bit auto_m;
    for (int it = 0; it < 8; it++) begin
      n    = $urandom_range(0, 6);
      mode = $urandom_range(0, 3);
      im   = $urandom_range(0, 1);
      auto_m = (mode == 1);
      nn   = (n == 0) ? 1 : n;
      kmax = auto_m ? 3 * (nn + 3) + 2 : nn + 6;
      do_reset();
      wr(4'h4, n);
      wr(4'h0, {28'd0, im[0], mode[1:0], 1'b1});
      for (int k = 1; k <= kmax; k++) begin
        @(posedge clk); #1;
        exp_c   = model_count(n, auto_m, k);
        exp_i   = im[0] & model_pend(n, auto_m, k);
        exp_ctl = {28'd0, im[0], mode[1:0], model_en(n, auto_m, k)};
        rd(4'h8, d);
        n_checks++;
        if (d !== exp_c) $display("FAIL rand%0d_count_e%0d: got %0d expected %0d (n=%0d mode=%0d)", it, k, d, exp_c, n, mode); else n_pass++;
        n_checks++;
        if (IRQ !== exp_i) $display("FAIL rand%0d_irq_e%0d: got %b expected %b (n=%0d mode=%0d im=%0d)", it, k, IRQ, exp_i, n, mode, im); else n_pass++;
        rd(4'h0, d);
        n_checks++;
        if (d !== exp_ctl) $display("FAIL rand%0d_ctrl_e%0d: got %h expected %h", it, k, d, exp_ctl); else n_pass++;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    WE    = 1'b0;
    Addr  = 32'd0;
    Din   = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_oneshot();
    test_autoreload();
    test_mask();
    test_disable();
    test_int_write();
    test_bus_decode();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
